// File: rtl/sim_sequencer.sv
// Run-control sequencer: holds the DUT in reset, runs it with a divided clock enable,
// stops on GPIO done or cycle budget, then requests a memory dump and latches the status.
module sim_sequencer #(
   parameter int unsigned RST_CYCLES     = 10,
   parameter int unsigned CLKEN_DIV      = 1,
   parameter int unsigned TIMEOUT_CYCLES = 40,
   parameter int unsigned GPIO_W         = 32,
   parameter int unsigned DONE_BIT       = 31,
   parameter int unsigned PASS_BIT       = 30
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [GPIO_W-1:0] i_gpio,
   input  logic              i_dump_ack,
   output logic              o_dut_rstb,
   output logic              o_clk_en,
   output logic              o_dump_req,
   output logic              o_done,
   output logic              o_pass,
   output logic              o_timeout,
   output logic [31:0]       o_cycle_count
);

   localparam logic [1:0] StHold     = 2'd0;
   localparam logic [1:0] StRun      = 2'd1;
   localparam logic [1:0] StDump     = 2'd2;
   localparam logic [1:0] StFinished = 2'd3;

   localparam logic [15:0] HoldLast   = 16'(RST_CYCLES);
   localparam logic [7:0]  DivLast    = 8'(CLKEN_DIV - 1);
   localparam logic [31:0] TimeoutVal = 32'(TIMEOUT_CYCLES);
   localparam bit          TimeoutOn  = (TIMEOUT_CYCLES != 0);

   logic [1:0]  state_q, state_d;
   logic [15:0] hold_q, hold_d;
   logic [7:0]  div_q, div_d;
   logic [31:0] count_q, count_d;
   logic        rstb_q, rstb_d;
   logic        clk_en_q, clk_en_d;
   logic        dump_req_q, dump_req_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        timeout_q, timeout_d;

   logic [31:0] count_inc;
   logic [7:0]  div_next;
   logic        done_hit;
   logic        tmo_hit;
   logic        unused_gpio;

   // Only the done and pass bits matter; the rest of the bus is observe-only.
   assign unused_gpio = ^i_gpio;

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      div_d      = div_q;
      count_d    = count_q;
      rstb_d     = rstb_q;
      clk_en_d   = clk_en_q;
      dump_req_d = dump_req_q;
      done_d     = done_q;
      pass_d     = pass_q;
      timeout_d  = timeout_q;

      count_inc = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
      div_next  = (div_q == DivLast) ? 8'd0 : div_q + 8'd1;
      done_hit  = i_gpio[DONE_BIT];
      tmo_hit   = TimeoutOn && (count_inc == TimeoutVal);

      case (state_q)
         StHold: begin
            rstb_d   = 1'b0;
            clk_en_d = 1'b0;
            if (hold_q == HoldLast) begin
               // Release and first enable pulse land on the same edge.
               state_d  = StRun;
               rstb_d   = 1'b1;
               clk_en_d = 1'b1;
               div_d    = 8'd0;
            end else begin
               hold_d = hold_q + 16'd1;
            end
         end
         StRun: begin
            div_d    = div_next;
            clk_en_d = (div_next == 8'd0);
            if (clk_en_q) begin
               count_d = count_inc;
               if (done_hit) begin
                  pass_d     = i_gpio[PASS_BIT];
                  timeout_d  = 1'b0;
                  state_d    = StDump;
                  clk_en_d   = 1'b0;
                  dump_req_d = 1'b1;
               end else if (tmo_hit) begin
                  pass_d     = 1'b0;
                  timeout_d  = 1'b1;
                  state_d    = StDump;
                  clk_en_d   = 1'b0;
                  dump_req_d = 1'b1;
               end
            end
         end
         StDump: begin
            clk_en_d = 1'b0;
            if (i_dump_ack) begin
               dump_req_d = 1'b0;
               done_d     = 1'b1;
               state_d    = StFinished;
            end
         end
         default: begin
            clk_en_d   = 1'b0;
            dump_req_d = 1'b0;
            done_d     = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= StHold;
         hold_q     <= 16'd0;
         div_q      <= 8'd0;
         count_q    <= 32'd0;
         rstb_q     <= 1'b0;
         clk_en_q   <= 1'b0;
         dump_req_q <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         div_q      <= div_d;
         count_q    <= count_d;
         rstb_q     <= rstb_d;
         clk_en_q   <= clk_en_d;
         dump_req_q <= dump_req_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         timeout_q  <= timeout_d;
      end
   end

   assign o_dut_rstb    = rstb_q;
   assign o_clk_en      = clk_en_q;
   assign o_dump_req    = dump_req_q;
   assign o_done        = done_q;
   assign o_pass        = pass_q;
   assign o_timeout     = timeout_q;
   assign o_cycle_count = count_q;

endmodule

// File: tb/tb_sim_sequencer.sv
// Bench for sim_sequencer: two instances (divider 1 and 3) checked every cycle against a
// behavioural model, plus directed scenarios with literal expectations.
module tb_sim_sequencer;

   localparam int unsigned R  = 10;
   localparam int unsigned TO = 40;

   logic        clk = 1'b0;
   logic [1:0]  rst, ack, rstb, clk_en, dreq, done, pass, tmo;
   logic [31:0] gpio [2];
   logic [31:0] cnt  [2];

   int n_pass  = 0;
   int n_total = 0;
   bit cmp_on  = 1'b0;

   always #5 clk = ~clk;

   sim_sequencer #(
      .RST_CYCLES(R), .CLKEN_DIV(1), .TIMEOUT_CYCLES(TO), .GPIO_W(32), .DONE_BIT(31),
      .PASS_BIT(30)
   ) u_dut0 (
      .i_clk(clk), .i_rst(rst[0]), .i_gpio(gpio[0]), .i_dump_ack(ack[0]),
      .o_dut_rstb(rstb[0]), .o_clk_en(clk_en[0]), .o_dump_req(dreq[0]), .o_done(done[0]),
      .o_pass(pass[0]), .o_timeout(tmo[0]), .o_cycle_count(cnt[0])
   );

   sim_sequencer #(
      .RST_CYCLES(R), .CLKEN_DIV(3), .TIMEOUT_CYCLES(TO), .GPIO_W(32), .DONE_BIT(31),
      .PASS_BIT(30)
   ) u_dut1 (
      .i_clk(clk), .i_rst(rst[1]), .i_gpio(gpio[1]), .i_dump_ack(ack[1]),
      .o_dut_rstb(rstb[1]), .o_clk_en(clk_en[1]), .o_dump_req(dreq[1]), .o_done(done[1]),
      .o_pass(pass[1]), .o_timeout(tmo[1]), .o_cycle_count(cnt[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Behavioural model: phase 0 hold, 1 run, 2 dump, 3 finished.
   int          m_phase [2];
   int          m_rel   [2];
   int          m_run_t [2];
   logic [31:0] m_cnt   [2];
   logic        m_pass  [2];
   logic        m_to    [2];

   function automatic int div_of(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic bit m_enabled(input int i);
      return (m_phase[i] == 1) && (m_run_t[i] % div_of(i) == 0);
   endfunction

   function automatic void model_step(input int i);
      if (rst[i]) begin
         m_phase[i] = 0; m_rel[i] = 0; m_run_t[i] = 0;
         m_cnt[i] = 0; m_pass[i] = 0; m_to[i] = 0;
      end else begin
         case (m_phase[i])
            0: begin
               m_rel[i]++;
               if (m_rel[i] == R + 1) begin
                  m_phase[i] = 1;
                  m_run_t[i] = 0;
               end
            end
            1: begin
               if (m_enabled(i)) begin
                  if (m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 1;
                  if (gpio[i][31]) begin
                     m_pass[i] = gpio[i][30]; m_to[i] = 0; m_phase[i] = 2;
                  end else if (TO != 0 && m_cnt[i] == TO) begin
                     m_pass[i] = 0; m_to[i] = 1; m_phase[i] = 2;
                  end
               end
               m_run_t[i]++;
            end
            2: if (ack[i]) m_phase[i] = 3;
            default: ;
         endcase
      end
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) model_step(i);
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         for (int i = 0; i < 2; i++) begin
            check($sformatf("dut%0d rstb", i), 32'(rstb[i]), 32'(m_phase[i] != 0));
            check($sformatf("dut%0d clk_en", i), 32'(clk_en[i]), 32'(m_enabled(i)));
            check($sformatf("dut%0d dump_req", i), 32'(dreq[i]), 32'(m_phase[i] == 2));
            check($sformatf("dut%0d done", i), 32'(done[i]), 32'(m_phase[i] == 3));
            check($sformatf("dut%0d pass", i), 32'(pass[i]), 32'(m_pass[i]));
            check($sformatf("dut%0d timeout", i), 32'(tmo[i]), 32'(m_to[i]));
            check($sformatf("dut%0d count", i), cnt[i], m_cnt[i]);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   // Called right after rst[i] is lowered at a negedge; ends on the release cycle.
   task automatic expect_hold(input int i, input string tag);
      for (int n = 1; n <= R + 1; n++) begin
         tick();
         if (n <= R) check({tag, " rstb held"}, 32'(rstb[i]), 32'd0);
      end
      check({tag, " rstb rise"}, 32'(rstb[i]), 32'd1);
      check({tag, " first clk_en"}, 32'(clk_en[i]), 32'd1);
      check({tag, " count restart"}, cnt[i], 32'd0);
   endtask

   task automatic wait_cnt(input int i, input logic [31:0] v, input int budget);
      int n = 0;
      while (cnt[i] !== v && n < budget) begin tick(); n++; end
      if (cnt[i] !== v) check("wait count timeout", cnt[i], v);
   endtask

   task automatic wait_done(input int i, input int budget);
      int n = 0;
      while (done[i] !== 1'b1 && n < budget) begin tick(); n++; end
      if (done[i] !== 1'b1) check("wait done timeout", 32'(done[i]), 32'd1);
   endtask

   task automatic wait_dreq(input int i, input int budget);
      int n = 0;
      while (dreq[i] !== 1'b1 && n < budget) begin tick(); n++; end
      if (dreq[i] !== 1'b1) check("wait dump_req timeout", 32'(dreq[i]), 32'd1);
   endtask

   task automatic reset_pulse(input int i, input string tag);
      rst[i] = 1'b1;
      tick();
      check({tag, " rstb"}, 32'(rstb[i]), 32'd0);
      check({tag, " clk_en"}, 32'(clk_en[i]), 32'd0);
      check({tag, " dump_req"}, 32'(dreq[i]), 32'd0);
      check({tag, " done"}, 32'(done[i]), 32'd0);
      check({tag, " pass"}, 32'(pass[i]), 32'd0);
      check({tag, " timeout"}, 32'(tmo[i]), 32'd0);
      check({tag, " count"}, cnt[i], 32'd0);
      rst[i] = 1'b0;
   endtask

   initial begin
      int dr;
      logic [31:0] r;
      rst = 2'b11; ack = 2'b00; gpio[0] = 32'd0; gpio[1] = 32'd0;
      tick(); tick();
      cmp_on = 1'b1;

      // Basic done exit
      ack[0] = 1'b1;
      rst[0] = 1'b0;
      expect_hold(0, "t1");
      wait_cnt(0, 32'd5, 20);
      gpio[0] = 32'hC000_0000;
      dr = 0;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (dreq[0]) dr++;
         if (done[0]) break;
      end
      check("t1 dump_req cycles", 32'(dr), 32'd1);
      check("t1 done", 32'(done[0]), 32'd1);
      check("t1 pass", 32'(pass[0]), 32'd1);
      check("t1 timeout", 32'(tmo[0]), 32'd0);
      check("t1 count", cnt[0], 32'd6);
      check("t1 model count", m_cnt[0], 32'd6);
      gpio[0] = 32'd0;

      // Timeout exit
      reset_pulse(0, "t2 reset");
      expect_hold(0, "t2");
      wait_done(0, 100);
      check("t2 timeout", 32'(tmo[0]), 32'd1);
      check("t2 pass", 32'(pass[0]), 32'd0);
      check("t2 count", cnt[0], 32'd40);
      for (int n = 0; n < 3; n++) begin
         tick();
         check("t2 clk_en low", 32'(clk_en[0]), 32'd0);
      end

      // Done and timeout on the same enabled cycle
      reset_pulse(0, "t4 reset");
      expect_hold(0, "t4");
      wait_cnt(0, 32'd39, 60);
      gpio[0] = 32'h8000_0000;
      wait_done(0, 10);
      check("t4 timeout", 32'(tmo[0]), 32'd0);
      check("t4 pass", 32'(pass[0]), 32'd0);
      check("t4 done", 32'(done[0]), 32'd1);
      check("t4 count", cnt[0], 32'd40);
      gpio[0] = 32'd0;

      // Dump handshake stall
      ack[0] = 1'b0;
      reset_pulse(0, "t5 reset");
      expect_hold(0, "t5");
      wait_cnt(0, 32'd3, 20);
      gpio[0] = 32'hC000_0000;
      wait_dreq(0, 5);
      gpio[0] = 32'd0;
      for (int n = 2; n <= 7; n++) begin
         tick();
         check("t5 dump_req held", 32'(dreq[0]), 32'd1);
         check("t5 count frozen", cnt[0], 32'd4);
      end
      ack[0] = 1'b1;
      tick();
      check("t5 done after ack", 32'(done[0]), 32'd1);
      check("t5 dump_req drop", 32'(dreq[0]), 32'd0);
      check("t5 count", cnt[0], 32'd4);

      // Reset mid-RUN and mid-DUMP
      ack[0] = 1'b0;
      reset_pulse(0, "t6 pre");
      expect_hold(0, "t6a");
      wait_cnt(0, 32'd8, 20);
      reset_pulse(0, "t6 run reset");
      expect_hold(0, "t6b");
      tick();
      check("t6 count after restart", cnt[0], 32'd1);
      gpio[0] = 32'h8000_0000;
      wait_dreq(0, 5);
      gpio[0] = 32'd0;
      reset_pulse(0, "t6 dump reset");
      expect_hold(0, "t6c");

      // Clock-enable divider on the second instance
      rst[0] = 1'b1;
      rst[1] = 1'b0;
      expect_hold(1, "t3");
      for (int k = 0; k <= 8; k++) begin
         if (k > 0) tick();
         check("t3 clk_en pattern", 32'(clk_en[1]), 32'(k % 3 == 0));
         check("t3 count", cnt[1], 32'((k + 2) / 3));
      end
      tick(); tick();
      check("t3 gap before pulse", 32'(clk_en[1]), 32'd0);
      gpio[1] = 32'hC000_0000;
      tick();
      gpio[1] = 32'd0;
      for (int k = 11; k <= 13; k++) begin
         check("t3 pulse ignored", 32'(dreq[1]), 32'd0);
         check("t3 count after pulse", cnt[1], 32'((k + 2) / 3));
         tick();
      end
      ack[1] = 1'b1;
      gpio[1] = 32'hC000_0000;
      wait_done(1, 10);
      check("t3 pass", 32'(pass[1]), 32'd1);
      check("t3 timeout", 32'(tmo[1]), 32'd0);
      gpio[1] = 32'd0;

      // Randomized traffic on both instances, checked by the model
      rst = 2'b00;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++) begin
            rst[i] = (done[i] && $urandom_range(0, 7) == 0) || ($urandom_range(0, 299) == 0);
            r = $urandom;
            r[31] = ($urandom_range(0, 24) == 0);
            gpio[i] = r;
            ack[i] = ($urandom_range(0, 2) == 0);
         end
         tick();
      end

      rst = 2'b11;
      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
